// File: rtl/noc_dispatch_if.sv
// Handshake bundle between the host dispatch controller and its requesters/NoC port.
// slave: the dispatch controller side; master: the surrounding environment.
interface noc_dispatch_if #(
    parameter int WIDTH   = 39,
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     inj_valid;
    logic [WIDTH-1:0]         inj_data;
    logic                     inj_ready;
    logic                     ej_valid;
    logic [WIDTH-1:0]         ej_data;
    logic                     ej_ready;

    modport slave (
        input  req_valid, req_data, inj_ready, ej_valid, ej_data,
        output req_ready, inj_valid, inj_data, ej_ready
    );

    modport master (
        output req_valid, req_data, inj_ready, ej_valid, ej_data,
        input  req_ready, inj_valid, inj_data, ej_ready
    );
endinterface

// File: rtl/noc_dispatch_ctrl.sv
// Host-port dispatch controller: round-robin injection with per-column ifmap credits
// and result counting. NOC_DISPATCH_STATS_EN enables the injection stall counter.
module noc_dispatch_ctrl #(
    parameter int WIDTH   = 39,
    parameter int NUM_REQ = 3,
    parameter int CREDITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [15:0]   num_results_i,
    noc_dispatch_if.slave bus,
    output logic          result_valid_o,
    output logic [28:0]   result_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [31:0]   stall_cnt_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = $clog2(CREDITS + 1);
    localparam logic [1:0] T_IFMAP  = 2'b01;
    localparam logic [1:0] T_RESULT = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic               enter_run;
    logic [15:0]        num_res_q;
    logic [15:0]        result_cnt_q;
    logic [CW-1:0]      credit_q [3];
    logic [CW-1:0]      credit_d [3];
    logic [IDX_W-1:0]   rr_q, rr_next;
    logic               inj_valid_q;
    logic [WIDTH-1:0]   inj_data_q;
    logic               result_valid_q;
    logic [28:0]        result_data_q;
    logic               err_q;

    logic [3:0]         col_avail, col_full;
    logic [NUM_REQ-1:0] elig;
    logic               load_ok;
    logic               gnt_any;
    logic [IDX_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]   gnt_pkt;
    logic [1:0]         ej_type, ej_col;
    logic               good_ret;
    logic               unused_ej;

    assign ej_type   = bus.ej_data[30:29];
    assign ej_col    = bus.ej_data[28:27];
    assign unused_ej = ^bus.ej_data[WIDTH-1:31];

    // Column 3 is not a PE column: treat it as permanently available / permanently full.
    always_comb begin
        col_avail = 4'b1000;
        col_full  = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            col_avail[c] = (credit_q[c] != '0);
            col_full[c]  = (credit_q[c] == CW'(CREDITS));
        end
    end

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req_valid[i];
            if (bus.req_data[i*WIDTH+29 +: 2] == T_IFMAP &&
                bus.req_data[i*WIDTH+35 +: 4] <= 4'd2 &&
                !col_avail[bus.req_data[i*WIDTH+35 +: 2]])
                elig[i] = 1'b0;
        end
    end

    assign load_ok = (state_q == RUN) && (!inj_valid_q || bus.inj_ready);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_pkt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!gnt_any && load_ok && elig[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(idx);
                gnt_pkt = bus.req_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (gnt_any)
            bus.req_ready[gnt_idx] = 1'b1;
    end

    assign rr_next = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

    assign good_ret = bus.ej_valid && (state_q == RUN) && (ej_type == T_RESULT) &&
                      !col_full[ej_col];

    // A consume and a return on the same column in one cycle cancel out.
    always_comb begin
        logic cons, ret;
        cons = 1'b0;
        ret  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            credit_d[c] = credit_q[c];
            cons = gnt_any && (gnt_pkt[30:29] == T_IFMAP) && (gnt_pkt[38:35] == 4'(c));
            ret  = good_ret && (ej_col == 2'(c));
            if (enter_run)
                credit_d[c] = CW'(CREDITS);
            else if (ret && !cons)
                credit_d[c] = credit_q[c] + CW'(1);
            else if (cons && !ret)
                credit_d[c] = credit_q[c] - CW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        enter_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_results_i == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = RUN;
                        enter_run = 1'b1;
                    end
                end
            end
            RUN: begin
                if (result_cnt_q + 16'(good_ret) == num_res_q)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            num_res_q      <= '0;
            result_cnt_q   <= '0;
            rr_q           <= '0;
            inj_valid_q    <= 1'b0;
            inj_data_q     <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            err_q          <= 1'b0;
            for (int c = 0; c < 3; c++)
                credit_q[c] <= CW'(CREDITS);
        end else begin
            state_q <= state_d;
            for (int c = 0; c < 3; c++)
                credit_q[c] <= credit_d[c];
            if (state_q == IDLE && start_i)
                num_res_q <= num_results_i;
            if (enter_run) begin
                result_cnt_q <= '0;
                rr_q         <= '0;
            end else begin
                result_cnt_q <= result_cnt_q + 16'(good_ret);
                if (gnt_any)
                    rr_q <= rr_next;
            end
            if (!inj_valid_q || bus.inj_ready) begin
                inj_valid_q <= gnt_any;
                if (gnt_any)
                    inj_data_q <= gnt_pkt;
            end
            result_valid_q <= good_ret;
            if (good_ret)
                result_data_q <= bus.ej_data[28:0];
            if (bus.ej_valid && !good_ret)
                err_q <= 1'b1;
        end
    end

`ifdef NOC_DISPATCH_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || enter_run)
            stall_cnt_q <= '0;
        else if (inj_valid_q && !bus.inj_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

    assign bus.ej_ready  = 1'b1;
    assign bus.inj_valid = inj_valid_q;
    assign bus.inj_data  = inj_data_q;
    assign result_valid_o = result_valid_q;
    assign result_data_o  = result_data_q;
    assign busy_o         = (state_q == RUN);
    assign done_o         = (state_q == DONE);
    assign err_o          = err_q;
endmodule
